// File: rtl/fir_tm_controller.sv
// Time-multiplexed FIR controller: sequences N+1 taps through one MAC per input sample.
// Optional macro FIR_CTRL_OVERLAP_EN lets a new sample be accepted in the same cycle the output is taken.
module fir_tm_controller #(
  parameter int N  = 4,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] smp_addr,
  output logic [AW-1:0] coef_addr,
  output logic          acc_clr,
  output logic          acc_en,
  input  logic          mac_ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ovf_sticky,
  output logic          busy
);

  localparam logic [AW-1:0] LP_LAST = AW'(N);
  localparam logic [AW-1:0] LP_TAPS = AW'(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_tap;
  logic          r_acc_en;
  logic          r_acc_clr;
  logic          r_ovf;
  logic          w_accept;
  logic          w_in_mac;
  logic          w_last_tap;
  logic [AW-1:0] w_smp;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = MAC;
        end
      end
      MAC: begin
        if (w_last_tap) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
`ifdef FIR_CTRL_OVERLAP_EN
        in_ready = out_ready;
        if (out_ready) begin
          w_next = in_valid ? MAC : IDLE;
        end
`else
        if (out_ready) begin
          w_next = IDLE;
        end
`endif
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (RESET) begin
      in_ready = 1'b0;
    end
    w_accept = in_ready & in_valid;
    wr_en    = w_accept;
  end

  assign w_in_mac   = (r_state == MAC);
  assign w_last_tap = w_in_mac && (r_tap == LP_LAST);
  // (base - k) mod (N+1); the AW-bit wrap cancels out because the true result lies in 0..N
  assign w_smp      = (r_base >= r_tap) ? (r_base - r_tap) : (r_base - r_tap + LP_TAPS);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wp      <= '0;
      r_base    <= '0;
      r_tap     <= '0;
      r_acc_en  <= 1'b0;
      r_acc_clr <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_acc_en  <= w_in_mac;
      r_acc_clr <= w_in_mac && (r_tap == '0);
      if (w_accept) begin
        r_base <= r_wp;
        r_tap  <= '0;
        r_wp   <= (r_wp == LP_LAST) ? '0 : r_wp + 1'b1;
        r_ovf  <= 1'b0;
      end else begin
        if (r_acc_en && mac_ovf) begin
          r_ovf <= 1'b1;
        end
        if (w_last_tap) begin
          r_tap <= '0;
        end else if (w_in_mac) begin
          r_tap <= r_tap + 1'b1;
        end
      end
    end
  end

  assign wr_addr    = r_wp;
  assign smp_addr   = w_in_mac ? w_smp : '0;
  assign coef_addr  = w_in_mac ? r_tap : '0;
  assign acc_en     = r_acc_en;
  assign acc_clr    = r_acc_clr;
  assign ovf_sticky = r_ovf;

endmodule

// File: doc/fir_tm_controller.md
FIR_TM_CONTROLLER -- requirements
Module: fir_tm_controller

Interface
REQ-001 SHALL have parameter N, default 4: filter order; tap count is N+1.
REQ-002 SHALL have parameter AW, default 3: sample/coefficient address width, with 2^AW >= N+1.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  new input sample offered.
REQ-006 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-007 SHALL have port wr_en  output  1  write the offered sample to the sample RAM.
REQ-008 SHALL have port wr_addr  output  AW  sample RAM write address.
REQ-009 SHALL have port smp_addr  output  AW  sample RAM read address.
REQ-010 SHALL have port coef_addr  output  AW  coefficient LUT read address.
REQ-011 SHALL have port acc_clr  output  1  accumulator loads the product instead of adding it.
REQ-012 SHALL have port acc_en  output  1  accumulator update enable.
REQ-013 SHALL have port mac_ovf  input  1  combined multiplier/adder overflow from the MAC.
REQ-014 SHALL have port out_valid  output  1  accumulator holds the final filtered output.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-016 SHALL have port ovf_sticky  output  1  overflow occurred during the current output's accumulation.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, MAC, DRAIN and HOLD.
REQ-019 SHALL, in IDLE, drive in_ready=1, wr_en=in_valid and wr_addr=wp, where wp is the write pointer.
REQ-020 SHALL, on an accept (in_valid & in_ready), latch base=wp, advance wp by one with wrap N->0, clear ovf_sticky and enter MAC.
REQ-021 SHALL stay in MAC for exactly N+1 cycles, with tap k=0..N issuing coef_addr=k and smp_addr=(base-k) mod (N+1).
REQ-022 SHALL account for the 1-cycle read latency of the sample RAM and LUT: acc_en is high the cycle after each tap issue, and acc_clr is high only with the tap-0 acc_en.
REQ-023 SHALL, after the last tap, spend one cycle in DRAIN (final acc_en) and then enter HOLD.
REQ-024 SHALL, in HOLD, drive out_valid=1 and in_ready=0, ignore in_valid, and return to IDLE on out_ready.
REQ-025 SHALL give a latency of N+3 cycles from accept to the first out_valid cycle, and a sample period of N+4 cycles when out_ready is held high.
REQ-026 SHALL set ovf_sticky when mac_ovf=1 in any cycle with acc_en=1, hold it through HOLD, and clear it only on the next accept.
REQ-027 SHALL hold smp_addr, coef_addr, acc_en and acc_clr at 0 outside the MAC and DRAIN issue cycles.

Reset
REQ-028 SHALL, while RESET=1, force in_ready=0 and wr_en=0 combinationally.
REQ-029 SHALL, on RESET, set state=IDLE, wp=0, base=0, the tap counter to 0, and drive all outputs to 0 on the next cycle (in_ready returns to 1 once RESET is low).
REQ-030 SHALL, on RESET mid-MAC, mid-DRAIN or mid-HOLD, abort with no out_valid and no further acc_en.

Configuration
REQ-031 SHALL, with macro FIR_CTRL_OVERLAP_EN defined, drive in_ready=out_ready in HOLD; a simultaneous out_ready & in_valid completes the output, accepts the sample (wr_en same cycle) and goes HOLD->MAC directly, giving a sample period of N+3.
REQ-032 SHALL, without FIR_CTRL_OVERLAP_EN, behave exactly per REQ-024 and REQ-025.

Verification (N=4, AW=3)
REQ-033 SHALL cover: reset, then accept at cycle 0 -> wr_addr=0; smp_addr 0,4,3,2,1 and coef_addr 0..4 in cycles 1-5; acc_clr in cycle 2; acc_en in cycles 2-6; out_valid in cycle 7.
REQ-034 SHALL cover: six back-to-back samples with out_ready=1 -> wr_addr 0,1,2,3,4,0; the second sample gives smp_addr 1,0,4,3,2; accepts spaced 8 cycles apart.
REQ-035 SHALL cover: out_ready=0 for 3 cycles in HOLD while in_valid=1 -> out_valid held for 4 cycles, in_ready=0 and wr_en=0 throughout.
REQ-036 SHALL cover: mac_ovf pulsed during the third acc_en cycle -> ovf_sticky=1 with out_valid; next sample with no overflow -> ovf_sticky=0.
REQ-037 SHALL cover: RESET asserted in the third MAC cycle -> acc_en=0 on the next cycle, state IDLE, wp=0, no out_valid; the next accept writes wr_addr=0.
REQ-038 SHALL cover, with FIR_CTRL_OVERLAP_EN: in_valid and out_ready both high in the first HOLD cycle -> wr_en in that cycle, MAC on the next cycle, accepts spaced 7 cycles apart.
